// File: rtl/ppc_types.sv
// Shared CDB types and constants for the out-of-order core.
// The CDB result type and the round-robin pointer-advance rule live here so other arbiters can reuse them.
package ppc_types;

    localparam int PPC_RS_ID_WIDTH = 5;
    localparam int CDB_UNITS       = 4;

    typedef struct packed {
        logic                       valid;
        logic [0:PPC_RS_ID_WIDTH-1] rs_id;
        logic [0:31]                value;
    } cdb_t;

    // Pointer position just past a granted requester, wrapping at n.
    function automatic int rr_next(input int k, input int n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Unit-result and CDB broadcast bundle of the CDB arbiter.
// Handshake: unit k transfers in any cycle where unit_valid[k] && unit_ready[k]. unit_ready is combinational and never high without unit_valid. A unit holds valid/rs_id/value stable until it is accepted. The CDB has no back-pressure.
interface cdb_arbiter_if #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);
    logic                   flush;
    logic                   unit_valid [0:NUM_UNITS-1];
    logic                   unit_ready [0:NUM_UNITS-1];
    logic [0:RS_ID_WIDTH-1] unit_rs_id [0:NUM_UNITS-1];
    logic [0:31]            unit_value [0:NUM_UNITS-1];
    logic                   cdb_valid;
    logic [0:RS_ID_WIDTH-1] cdb_rs_id;
    logic [0:31]            cdb_value;

    modport master (
        input  flush, unit_valid, unit_rs_id, unit_value,
        output unit_ready, cdb_valid, cdb_rs_id, cdb_value
    );

    modport slave (
        output flush, unit_valid, unit_rs_id, unit_value,
        input  unit_ready, cdb_valid, cdb_rs_id, cdb_value
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from an owned priority pointer.
// The pointer moves past the winner only when a grant is issued.
module round_robin_arbiter
    import ppc_types::*;
#(
    parameter int N = CDB_UNITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:N-1]         req,
    input  logic                 enable,
    output logic [0:N-1]         grant,
    output logic [$clog2(N)-1:0] ptr_o
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] rr_ptr_ff;
    logic [PW-1:0] rr_ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr_ff) + i;
            if (idx >= N) idx = idx - N;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_ff;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) rr_ptr_d = PW'(rr_next(k, N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_ff <= '0;
        else     rr_ptr_ff <= rr_ptr_d;
    end

    assign ptr_o = rr_ptr_ff;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one unit result per cycle, broadcast on the CDB.
// Macro CDB_OUTPUT_REG_EN: defined gives registered CDB outputs (1-cycle latency); undefined gives a combinational broadcast.
module cdb_arbiter
    import ppc_types::*;
#(
    parameter int NUM_UNITS   = CDB_UNITS,
    parameter int RS_ID_WIDTH = PPC_RS_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    cdb_arbiter_if.master                bus,
    output logic [$clog2(NUM_UNITS)-1:0] rr_ptr_o
);
    logic [0:NUM_UNITS-1]   req;
    logic [0:NUM_UNITS-1]   grant;
    logic                   enable;
    logic                   sel_valid;
    logic [0:RS_ID_WIDTH-1] sel_rs_id;
    logic [0:31]            sel_value;

    // Reset and flush both hold every unit off; reset wins regardless.
    assign enable = ~(bus.flush | rst);

    always_comb begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            req[k]            = bus.unit_valid[k];
            bus.unit_ready[k] = grant[k];
        end
    end

    round_robin_arbiter #(
        .N (NUM_UNITS)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .enable (enable),
        .grant  (grant),
        .ptr_o  (rr_ptr_o)
    );

    // One-hot grant lets an AND-OR mux select the result; zero when nothing is granted.
    always_comb begin
        sel_valid = 1'b0;
        sel_rs_id = '0;
        sel_value = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (grant[k]) begin
                sel_valid = 1'b1;
                sel_rs_id = sel_rs_id | bus.unit_rs_id[k];
                sel_value = sel_value | bus.unit_value[k];
            end
        end
    end

`ifdef CDB_OUTPUT_REG_EN
    logic                   cdb_valid_q;
    logic [0:RS_ID_WIDTH-1] cdb_rs_id_q;
    logic [0:31]            cdb_value_q;

    // ID and value keep their last broadcast when no grant is made.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_rs_id_q <= '0;
            cdb_value_q <= '0;
        end else begin
            cdb_valid_q <= sel_valid;
            if (sel_valid) begin
                cdb_rs_id_q <= sel_rs_id;
                cdb_value_q <= sel_value;
            end
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_rs_id = cdb_rs_id_q;
    assign bus.cdb_value = cdb_value_q;
`else
    assign bus.cdb_valid = sel_valid;
    assign bus.cdb_rs_id = sel_rs_id;
    assign bus.cdb_value = sel_value;
`endif

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB). It grants one functional-unit result per cycle and broadcasts the granted result's reservation-station ID and value. The broadcast feeds the operand-update ports (`operand_valid`, `update_op_rs_id_in`, `update_op_value_in`) of every reservation station, and sits between the unit outputs and the operand forwarding network.

## Interface
- `NUM_UNITS`, default 4: number of requesting functional units; must be ≥ 2.
- `RS_ID_WIDTH`, default 5: width of the reservation-station ID; must match the system-wide RS ID width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous kill; suppresses grants and broadcasts.
- `unit_valid[0:NUM_UNITS-1]`  in  1 each  unit k offers a result.
- `unit_ready[0:NUM_UNITS-1]`  out  1 each  unit k's result is accepted this cycle.
- `unit_rs_id[0:NUM_UNITS-1]`  in  `[0:RS_ID_WIDTH-1]` each  ID of the station that produced the result.
- `unit_value[0:NUM_UNITS-1]`  in  `[0:31]` each  result value.
- `cdb_valid`  out  1  broadcast is valid.
- `cdb_rs_id`  out  `[0:RS_ID_WIDTH-1]`  broadcast station ID.
- `cdb_value`  out  `[0:31]`  broadcast value.

## Operation
- Handshake: a transfer from unit k happens in any cycle where `unit_valid[k] & unit_ready[k]`.
  - `unit_ready` is combinational from `unit_valid`, the priority pointer and `flush`.
  - At most one `unit_ready` bit is high per cycle.
  - A unit holds `valid`, `rs_id` and `value` stable until accepted.
  - `unit_ready[k]` is never high while `unit_valid[k]` is low.
- Priority pointer `rr_ptr_ff`:
  - Width is `$clog2(NUM_UNITS)`; reset value 0.
  - The search starts at index `rr_ptr_ff` and increments with wrap-around modulo `NUM_UNITS`.
  - The first unit found with `unit_valid` high is granted.
- Pointer update:
  - On a grant to unit k, `rr_ptr_ff <= (k == NUM_UNITS-1) ? 0 : k+1`.
  - With no grant, or with `flush` high, the pointer is unchanged.
- `flush` high:
  - All `unit_ready` are 0, so no result is consumed.
  - `cdb_valid` deasserts as described in Timing.
  - Units keep their pending results.
- No CDB back-pressure: reservation stations always accept a broadcast.
- Width rules: the ID and value are passed unmodified. No arithmetic other than the pointer increment.

## Timing
- Reset values:
  - `cdb_valid` = 0, `cdb_rs_id` = 0, `cdb_value` = 0, `rr_ptr_ff` = 0.
  - `unit_ready` = 0 in any cycle with `rst` high; `rst` overrides `flush` and all requests.
- Latency is 1 cycle by default (registered output; see Configuration).
  - A result accepted in cycle N appears on the CDB in cycle N+1 with `cdb_valid` = 1.
  - Sustained throughput is 1 result per cycle.
- With no grant in cycle N, `cdb_valid` = 0 in cycle N+1. `cdb_rs_id` and `cdb_value` hold their last values.
- `flush` in cycle N forces `cdb_valid` = 0 in cycle N+1. A broadcast already registered before cycle N remains visible during cycle N.
- Simultaneous requests from all units are served in rotating order. Worst-case wait for a continuously requesting unit is `NUM_UNITS-1` cycles.
- When `rst` is asserted mid-stream, the in-flight broadcast is dropped next cycle and the pointer returns to 0.

## Configuration
- Macro: `CDB_OUTPUT_REG_EN`.
- Defined (default build):
  - CDB outputs are flip-flops with the 1-cycle latency above.
  - `flush` acts on the next cycle.
- Undefined:
  - CDB outputs are combinational from the granted unit in the same cycle (0 latency).
  - When `cdb_valid` = 0, `cdb_rs_id` and `cdb_value` are 0.
  - `flush` forces `cdb_valid` = 0 in the same cycle.
  - Pointer behaviour is identical in both builds.

## Structure
- In package `ppc_types`:
  - typedef `cdb_t` (struct: `valid`, `rs_id`, `value`), using the package-wide RS ID width constant.
  - constant `CDB_UNITS` = 4 for the default system.
- Sub-module `round_robin_arbiter`:
  - Parameter `N`; inputs `req[0:N-1]` and `enable`; outputs a one-hot `grant[0:N-1]` and the owned pointer register.
  - Reusable later for dispatch arbitration.
- `cdb_arbiter` instantiates it and adds the result mux, the output register and `flush` handling.

## Test plan
- Reset, then unit 2 only valid (`rs_id`=5, `value`=0xDEADBEEF) → `unit_ready[2]`=1 that cycle; next cycle `cdb_valid`=1, `cdb_rs_id`=5, `cdb_value`=0xDEADBEEF; `rr_ptr_ff`=3.
- All 4 units valid continuously for 8 cycles from reset → grants in order 0,1,2,3,0,1,2,3; exactly one `unit_ready` per cycle.
- `rr_ptr_ff`=3 with units 1 and 3 valid → unit 3 granted, pointer wraps to 0; next grant goes to unit 1.
- `flush`=1 with units 0 and 1 valid → `unit_ready` all 0, `cdb_valid`=0 next cycle, pointer unchanged; after `flush` drops, unit at the pointer is granted first.
- `rst` asserted while `cdb_valid`=1 and requests are pending → next cycle `cdb_valid`=0, `cdb_rs_id`=0, `cdb_value`=0, pointer 0.
- Build without `CDB_OUTPUT_REG_EN`: unit 1 valid (`rs_id`=9, `value`=0x12345678) → same-cycle `cdb_valid`=1, `cdb_rs_id`=9, `cdb_value`=0x12345678.
